// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: next-PC generator and F-stage PC register for the pipelined
// MIPS core. It resolves branches and jumps for the instruction in D, with one
// delay slot. A redirect that resolves while fetch is stalled is buffered so
// that D can advance independently of F.
// Optional build macro EXC_REDIRECT_EN adds exception entry and ERET redirects
// (ports exc_req, eret_req and epc).
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_stall,
  input  logic              d_fire,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [3:0]        d_br_op,
  input  logic [25:0]       d_imm26,
  input  logic [31:0]       d_rs_val,
  input  logic [31:0]       d_rt_val,
`ifdef EXC_REDIRECT_EN
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] f_pc,
  output logic              d_taken,
  output logic [ADDR_W-1:0] d_link,
  output logic              pend_valid,
  output logic              f_misalign,
  output logic              seq_err
);

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JR   = 4'd8
  } br_op_e;

  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [31:0]       br_off32;
  logic [31:0]       pc4_32;
  logic [31:0]       j32;
  logic [ADDR_W-1:0] d_target;
  logic              d_cond;

  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pt_nxt;
  logic              pv_nxt;
  logic              se_nxt;
  logic              pc_upd;

  // Candidate targets for each branch/jump class
  always_comb begin
    br_off32 = {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
    pc_plus4 = d_pc + ADDR_W'(4);
    br_tgt   = pc_plus4 + ADDR_W'($signed(br_off32));
    // Jump region bits come from the 32-bit view of d_pc+4, so narrower PCs
    // see zeros there.
    pc4_32   = 32'(d_pc) + 32'd4;
    j32      = (pc4_32 & 32'hF000_0000) | {4'b0000, d_imm26, 2'b00};
    j_tgt    = ADDR_W'(j32);
    jr_tgt   = ADDR_W'(d_rs_val);
    d_link   = d_pc + ADDR_W'(8);
  end

  // Branch condition evaluation and target selection for the D instruction
  always_comb begin
    d_cond   = 1'b0;
    d_target = '0;
    case (d_br_op)
      BR_BEQ:  begin d_cond = (d_rs_val == d_rt_val);          d_target = br_tgt; end
      BR_BNE:  begin d_cond = (d_rs_val != d_rt_val);          d_target = br_tgt; end
      BR_BLEZ: begin d_cond = ($signed(d_rs_val) <= 32'sd0);   d_target = br_tgt; end
      BR_BGTZ: begin d_cond = ($signed(d_rs_val) >  32'sd0);   d_target = br_tgt; end
      BR_BLTZ: begin d_cond = ($signed(d_rs_val) <  32'sd0);   d_target = br_tgt; end
      BR_BGEZ: begin d_cond = ($signed(d_rs_val) >= 32'sd0);   d_target = br_tgt; end
      BR_J:    begin d_cond = 1'b1;                            d_target = j_tgt;  end
      BR_JR:   begin d_cond = 1'b1;                            d_target = jr_tgt; end
      default: begin d_cond = 1'b0;                            d_target = '0;     end
    endcase
    d_taken = d_fire & d_cond;
  end

  // Next-PC priority: buffered redirect, fresh redirect, sequential, stall capture
  always_comb begin
    pc_nxt = f_pc;
    pt_nxt = pend_tgt;
    pv_nxt = pend_valid;
    se_nxt = seq_err;
    pc_upd = 1'b0;
    if (!f_stall) begin
      pc_upd = 1'b1;
      if (pend_valid) begin
        // Buffered redirect wins; a new redirect now would be a second one.
        pc_nxt = pend_tgt;
        pv_nxt = 1'b0;
        if (d_taken) se_nxt = 1'b1;
      end else if (d_taken) begin
        pc_nxt = d_target;
      end else begin
        pc_nxt = f_pc + ADDR_W'(4);
      end
    end else if (d_taken) begin
      if (!pend_valid) begin
        pt_nxt = d_target;
        pv_nxt = 1'b1;
      end else begin
        se_nxt = 1'b1;
      end
    end
`ifdef EXC_REDIRECT_EN
    // Exception/ERET override everything, including stall, and discard any
    // redirect capture from D in the same cycle.
    if (exc_req) begin
      pc_nxt = EXC_VEC;
      pc_upd = 1'b1;
      pt_nxt = pend_tgt;
      pv_nxt = 1'b0;
      se_nxt = seq_err;
    end else if (eret_req) begin
      pc_nxt = epc;
      pc_upd = 1'b1;
      pt_nxt = pend_tgt;
      pv_nxt = 1'b0;
      se_nxt = seq_err;
    end
`endif
  end

  // PC, pending-redirect buffer and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_pc       <= RESET_PC;
      pend_tgt   <= '0;
      pend_valid <= 1'b0;
      f_misalign <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      f_pc       <= pc_nxt;
      pend_tgt   <= pt_nxt;
      pend_valid <= pv_nxt;
      seq_err    <= se_nxt;
      if (pc_upd) f_misalign <= (pc_nxt[1:0] != 2'b00);
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised next-PC generator and fetch PC register for the pipelined MIPS core.
- Owns the F-stage PC.
- Resolves all branch and jump types for the instruction in D, with one delay slot.
- Buffers a redirect that resolves while fetch is stalled, so D may advance independently of F.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
ADDR_W, 32, PC and target width (upper bits zero-extended/truncated from 32-bit operands)
EXC_VEC, 32'h0000_4180, exception entry address (used only with optional feature)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
f_stall  input  1  hold F-stage PC this cycle
d_fire  input  1  D-stage instruction is valid and leaves D this cycle (branch resolves exactly once)
d_pc  input  ADDR_W  PC of instruction in D
d_br_op  input  4  0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J/JAL, 8 JR/JALR; 9-15 treated as NONE
d_imm26  input  26  instr[25:0]; imm16 = d_imm26[15:0]
d_rs_val  input  32  forwarded rs value
d_rt_val  input  32  forwarded rt value
f_pc  output  ADDR_W  current fetch PC (registered)
d_taken  output  1  combinational: D instruction redirects fetch
d_link  output  ADDR_W  d_pc+8, link value for JAL/JALR
pend_valid  output  1  registered: a redirect is buffered
f_misalign  output  1  registered: f_pc[1:0] != 0
seq_err  output  1  sticky: second redirect fired while one was pending

Behaviour:
- Reset (async, reset_n=0):
  - f_pc=RESET_PC; pend_valid=0; pend_tgt=0; f_misalign=0; seq_err=0.
  - Release is synchronous to clk.
- Conditions (signed 32-bit compares):
  - BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0.
  - J/JR: always taken.
- Targets:
  - Conditional branches: d_pc+4+(sext(imm16)<<2), modulo 2^ADDR_W.
  - J: {(d_pc+4)[31:28], imm26, 2'b00}.
  - JR: d_rs_val, unmodified; misaligned values are not masked.
- d_taken = d_fire & condition true. With d_fire=0, d_taken=0 and no state change from D inputs.
- Next-PC priority on each rising edge:
  1. f_stall=0 & pend_valid: f_pc<=pend_tgt; pend_valid<=0. If d_taken also asserts this cycle, set seq_err and drop the new target.
  2. f_stall=0 & d_taken: f_pc<=target.
  3. f_stall=0: f_pc<=f_pc+4 (wraps).
  4. f_stall=1 & d_taken & !pend_valid: f_pc holds; pend_tgt<=target; pend_valid<=1.
  5. f_stall=1 & d_taken & pend_valid: hold everything; set seq_err.
  6. f_stall=1 otherwise: hold.
- Latency: a redirect seen in cycle N with no stall appears on f_pc in cycle N+1. The delay-slot instruction is the one fetched at f_pc during cycle N.
- f_misalign is updated with f_pc and reflects the new value's low bits.
- seq_err clears only on reset.
- Reset mid-stall: pending redirect is discarded.

Optional Feature:
EXC_REDIRECT_EN:
- Defined: adds three inputs:
  - exc_req (1)
  - eret_req (1)
  - epc (ADDR_W)
- Priority exc_req > eret_req > normal rules. Both act regardless of f_stall.
  - exc_req: f_pc<=EXC_VEC.
  - eret_req: f_pc<=epc.
  - Both clear pend_valid and suppress any d_taken capture that cycle.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset, f_stall=0 for 3 cycles, no branches -> f_pc 0x3000, 0x3004, 0x3008, 0x300C.
- d_fire, BEQ, d_pc=0x3010, imm16=0xFFFC, rs=rt=5 -> d_taken=1, next f_pc=0x3004. Repeat with rt=6 -> d_taken=0, f_pc+4.
- f_stall=1 with JR rs=0x3400 fired -> f_pc holds, pend_valid=1. Hold stall 3 cycles, release -> f_pc=0x3400, pend_valid=0 next edge.
- Pending set, second J fired under stall -> seq_err=1 sticky, f_pc later = first target. Assert reset_n=0 -> seq_err=0, f_pc=0x3000 immediately.
- BLTZ rs=0x80000000 taken; BGEZ rs=0 taken; BGTZ rs=0 not taken; JR rs=0x3402 -> f_misalign=1.
- EXC_REDIRECT_EN: exc_req during f_stall with pend_valid=1 -> f_pc=0x4180, pend_valid=0. eret_req epc=0x3020 -> f_pc=0x3020.
